// File: rtl/dsp_pkg.sv
// Shared constants and bundles for the DSP48A1-style slice.
package dsp_pkg;

  localparam int P_W = 48;

  localparam int OPM_SUB = 7;
  localparam int OPM_CIN = 5;

  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

  typedef struct packed {
    logic           valid;
    logic           is_sub;
    logic           c_in;
    logic [P_W-1:0] z;
    logic [P_W-1:0] x;
  } op_t;

  typedef struct packed {
    logic           valid;
    logic           co;
    logic [P_W-1:0] s;
  } p_t;

  // Signed overflow of z +/- x judged from the operand and result sign bits.
  function automatic logic ovf_calc(
    input logic is_sub,
    input logic x_msb,
    input logic z_msb,
    input logic s_msb
  );
    if (is_sub)
      return (x_msb != z_msb) && (s_msb != z_msb);
    return (x_msb == z_msb) && (s_msb != z_msb);
  endfunction

endpackage

// File: rtl/dsp_post_adder_pipe_reg.sv
// Bypassable pipeline register with clock enable and async active-high reset.
module dsp_pipe_reg #(
  parameter int W  = 1,
  parameter bit EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (EN) begin : g_reg
      logic [W-1:0] q_r;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          q_r <= '0;
        else if (ce)
          q_r <= d;
      end
      assign q = q_r;
    end else begin : g_byp
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/dsp_post_adder.sv
// Post-adder/subtracter and P output stage of a DSP48A1-style slice.
// Sticky signed overflow flag is built only with DSP_POST_ADDER_OVF_EN.
module dsp_post_adder
  import dsp_pkg::*;
#(
  parameter int OPREG = 1,
  parameter int PREG  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce_op,
  input  logic           ce_p,
  input  logic           in_valid,
  input  logic [P_W-1:0] x_in,
  input  logic [P_W-1:0] z_in,
  input  logic           cin,
  input  logic           sub,
  input  logic           clr_ovf,
  output logic [P_W-1:0] p,
  output logic [P_W-1:0] pcout,
  output logic           carryout,
  output logic           carryoutf,
  output logic           out_valid,
  output logic           ovf
);

  op_t op_d;
  op_t op_q;
  p_t  p_d;
  p_t  p_q;

  assign op_d = '{
    valid:  in_valid,
    is_sub: sub,
    c_in:   cin,
    z:      z_in,
    x:      x_in
  };

  dsp_pipe_reg #(
    .W  ($bits(op_t)),
    .EN (OPREG != 0)
  ) u_op_reg (
    .clk (clk),
    .rst (rst),
    .ce  (ce_op),
    .d   (op_d),
    .q   (op_q)
  );

  logic [P_W:0]   rhs_w;
  logic [P_W:0]   sum_w;
  logic           co;
  logic [P_W-1:0] s;

  // Subtract carry-out is the inverted borrow of the 49-bit difference.
  always_comb begin
    rhs_w = {1'b0, op_q.x} + {{P_W{1'b0}}, op_q.c_in};
    sum_w = '0;
    co    = 1'b0;
    if (op_q.is_sub) begin
      sum_w = {1'b0, op_q.z} - rhs_w;
      co    = ~sum_w[P_W];
    end else begin
      sum_w = {1'b0, op_q.z} + rhs_w;
      co    = sum_w[P_W];
    end
    s = sum_w[P_W-1:0];
  end

  assign p_d = '{valid: op_q.valid, co: co, s: s};

  dsp_pipe_reg #(
    .W  ($bits(p_t)),
    .EN (PREG != 0)
  ) u_p_reg (
    .clk (clk),
    .rst (rst),
    .ce  (ce_p),
    .d   (p_d),
    .q   (p_q)
  );

  assign p         = p_q.s;
  assign pcout     = p_q.s;
  assign carryout  = p_q.co;
  assign carryoutf = p_q.co;
  assign out_valid = p_q.valid;

`ifdef DSP_POST_ADDER_OVF_EN
  logic ovf_now;
  logic ovf_set;
  logic ovf_q;

  assign ovf_now = ovf_calc(op_q.is_sub, op_q.x[P_W-1],
                            op_q.z[P_W-1], s[P_W-1]);
  assign ovf_set = ovf_now && ((PREG == 0) || ce_p);

  // A new overflow beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (ovf_set)
      ovf_q <= 1'b1;
    else if (clr_ovf)
      ovf_q <= 1'b0;
  end

  assign ovf = ovf_q;
`else
  logic unused_clr;
  assign unused_clr = clr_ovf;
  assign ovf        = 1'b0;
`endif

endmodule
